// File: rtl/cam_pkg.sv
// Purpose: shared types and constants for the camera capture sequencer.
// Contents: FSM state enum, RGB444 pixel width, default VGA/QVGA geometry,
//           and the byte-pair to {B,G,R} nibble repack helper.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        SYNC    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } cam_state_e;

    localparam int RGB444_W   = 12;
    localparam int LINE_CNT_W = 10;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int QVGA_H_ACTIVE = 320;
    localparam int QVGA_V_ACTIVE = 240;

    // First byte carries R in its low nibble, second byte carries {G,B}.
    function automatic logic [RGB444_W-1:0] rgb444_pack(input logic [3:0] red,
                                                        input logic [7:0] byte1);
        return {byte1[3:0], byte1[7:4], red};
    endfunction

endpackage

// File: rtl/cam_byte_pair.sv
// Purpose: pairs DVP bytes into RGB444 pixels while href is high.
// Ports:   href_i/data_i raw camera line; pix_valid_o/pix_data_o combinational
//          pixel strobe on the second byte; phase_o = a first byte is held.
module cam_byte_pair
    import cam_pkg::*;
(
    input  logic                cam_clk,
    input  logic                rstn,
    input  logic                href_i,
    input  logic [7:0]          data_i,
    output logic                pix_valid_o,
    output logic [RGB444_W-1:0] pix_data_o,
    output logic                phase_o
);

    logic       phase_q, phase_d;
    logic [3:0] red_q, red_d;

    always_comb begin
        phase_d = phase_q;
        red_d   = red_q;
        if (!href_i) begin
            // Phase restarts on every line so a trailing odd byte never
            // leaks into the next line.
            phase_d = 1'b0;
        end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                red_d = data_i[3:0];
            end
        end
    end

    always_ff @(posedge cam_clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= 1'b0;
            red_q   <= 4'h0;
        end else begin
            phase_q <= phase_d;
            red_q   <= red_d;
        end
    end

    assign pix_valid_o = href_i & phase_q;
    assign pix_data_o  = rgb444_pack(red_q, data_i);
    assign phase_o     = phase_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Purpose: frame-capture sequencer from camera DVP pins to a frame-buffer write port.
// Ports:   arm_i/abort_i/continuous_i control; cam_vsync_i/cam_href_i/cam_data_i camera;
//          wr_en_o/wr_addr_o/wr_data_o buffer write; busy_o/frame_done_o/frame_err_o/line_count_o status.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int ADDR_W   = 19
) (
    input  logic                  cam_clk,
    input  logic                  rstn,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  continuous_i,
    input  logic                  cam_vsync_i,
    input  logic                  cam_href_i,
    input  logic [7:0]            cam_data_i,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [RGB444_W-1:0]   wr_data_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  frame_err_o,
    output logic [LINE_CNT_W-1:0] line_count_o
);

    // One spare bit so an over-long line is still distinguishable from H_ACTIVE.
    localparam int                    PIX_W     = $clog2(H_ACTIVE + 1) + 1;
    localparam logic [PIX_W-1:0]      H_LIM     = PIX_W'(H_ACTIVE);
    localparam logic [LINE_CNT_W-1:0] V_LIM     = LINE_CNT_W'(V_ACTIVE);
    localparam logic [ADDR_W:0]       FRAME_PIX = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

    cam_state_e state_q, state_d;

    logic                  vsync_q, href_q;
    logic                  vs_rise, vs_fall, line_end;
    logic                  capturing, arm_ok, sync_entry;

    logic                  pix_valid, pix_phase;
    logic [RGB444_W-1:0]   pix_data;

    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d, pix_cnt_eff;
    logic                  pix_inc;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  line_inc;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [RGB444_W-1:0]   wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  line_err, geom_err;

    assign vs_rise  = cam_vsync_i & ~vsync_q;
    assign vs_fall  = ~cam_vsync_i & vsync_q;
    // A vsync rise in mid-line closes that line just like an href fall.
    assign line_end = href_q & (~cam_href_i | vs_rise);

    cam_byte_pair u_pair (
        .cam_clk     (cam_clk),
        .rstn        (rstn),
        .href_i      (cam_href_i),
        .data_i      (cam_data_i),
        .pix_valid_o (pix_valid),
        .pix_data_o  (pix_data),
        .phase_o     (pix_phase)
    );

    // ---------------- FSM ----------------
    always_comb begin
        state_d      = state_q;
        busy_o       = (state_q != IDLE);
        frame_done_o = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (arm_i)   state_d = WAIT_VS;
            // Wait for a fresh frame start so a partial frame is never captured.
            WAIT_VS: if (vs_rise) state_d = SYNC;
            SYNC:    if (vs_fall) state_d = CAPTURE;
            CAPTURE: if (vs_rise) state_d = DONE;
            DONE:    state_d = continuous_i ? SYNC : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
        end
    end

    assign capturing  = (state_q == CAPTURE);
    assign arm_ok     = (state_q == IDLE) & arm_i & ~abort_i;
    assign sync_entry = (state_d == SYNC) & (state_q != SYNC);

    // ---------------- counters, write path, errors ----------------
    always_comb begin
        pix_inc     = pix_valid & capturing & (pix_cnt_q != '1);
        pix_cnt_eff = pix_cnt_q + PIX_W'(pix_inc);
        pix_cnt_d   = pix_cnt_q;
        if (line_end || sync_entry) begin
            pix_cnt_d = '0;
        end else if (pix_inc) begin
            pix_cnt_d = pix_cnt_eff;
        end

        line_inc   = line_end & capturing & (line_cnt_q != '1);
        line_cnt_d = line_cnt_q;
        if (sync_entry) begin
            line_cnt_d = '0;
        end else if (line_inc) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
        end

        // Excess pixels/lines and anything past the frame end are dropped;
        // abort suppresses the pixel completing in the same cycle.
        wr_en_d   = pix_valid & capturing & ~abort_i
                  & (pix_cnt_q < H_LIM) & (line_cnt_q < V_LIM)
                  & ({1'b0, wr_addr_q} < FRAME_PIX);
        wr_data_d = pix_valid ? pix_data : wr_data_q;

        wr_addr_d = wr_addr_q;
        if (sync_entry) begin
            wr_addr_d = '0;
        end else if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        // Odd byte count shows as a held first byte when href drops.
        line_err = line_end & capturing
                 & ((pix_cnt_eff != H_LIM) | (pix_phase & ~cam_href_i));
        geom_err = (state_q == DONE) & (line_cnt_q != V_LIM);

        frame_err_d = frame_err_q;
        if (arm_ok) begin
            frame_err_d = 1'b0;
        end else if (line_err || geom_err) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge cam_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= cam_vsync_i;
            href_q      <= cam_href_i;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_err_o  = frame_err_q;
    assign line_count_o = line_cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic          cam_clk = 1'b0;
    logic          rstn    = 1'b0;
    logic          arm_i = 1'b0, abort_i = 1'b0, continuous_i = 1'b0;
    logic          cam_vsync_i = 1'b0, cam_href_i = 1'b0;
    logic [7:0]    cam_data_i = 8'h00;
    logic          wr_en_o, busy_o, frame_done_o, frame_err_o;
    logic [AW-1:0] wr_addr_o;
    logic [11:0]   wr_data_o;
    logic [9:0]    line_count_o;

    always #5 cam_clk = ~cam_clk;

    cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .cam_clk      (cam_clk),
        .rstn         (rstn),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .continuous_i (continuous_i),
        .cam_vsync_i  (cam_vsync_i),
        .cam_href_i   (cam_href_i),
        .cam_data_i   (cam_data_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_err_o  (frame_err_o),
        .line_count_o (line_count_o)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: what the capture must produce, frame by frame.
    bit m_armed = 0, m_cap = 0, m_err = 0;
    int m_addr = 0, m_lines = 0;
    int exp_addr_q[$];
    int exp_data_q[$];
    int exp_done_lines_q[$];
    int exp_done_err_q[$];

    int  n_writes = 0, n_done = 0, last_addr = -1;
    bit  mon_en = 0, chk_err_next = 0;
    int  pend_err = 0;

    int  opt_abort_line = -1, opt_abort_byte = -1, opt_arm_line = -1;
    bit  opt_fixed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit vs, input bit hr, input logic [7:0] d);
        cam_vsync_i = vs;
        cam_href_i  = hr;
        cam_data_i  = d;
        @(negedge cam_clk);
    endtask

    function automatic bit m_busy();
        return m_armed | m_cap;
    endfunction

    task automatic model_arm();
        if (!m_busy()) begin
            m_armed = 1;
            m_err   = 0;
        end
    endtask

    task automatic do_arm();
        arm_i = 1'b1;
        model_arm();
        tick(1'b0, 1'b0, 8'h00);
        arm_i = 1'b0;
    endtask

    // Start of a frame: closes the frame being captured, if any.
    task automatic vsync_pulse();
        bit nc;
        if (m_cap) begin
            if (m_lines != V) m_err = 1;
            exp_done_lines_q.push_back(m_lines);
            exp_done_err_q.push_back(int'(m_err));
        end
        nc      = (m_cap && continuous_i) || m_armed;
        m_armed = 0;
        m_cap   = nc;
        m_addr  = 0;
        m_lines = 0;
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int l, input int nbytes);
        logic [7:0] d;
        logic [3:0] red;
        bit ab, ar, fixed_cap, was_cap;
        int gap;
        red = 4'h0;
        fixed_cap = opt_fixed && (l == 0) && m_cap;
        for (int b = 0; b < nbytes; b++) begin
            if (opt_fixed && l == 0 && b == 0)      d = 8'h0A;
            else if (opt_fixed && l == 0 && b == 1) d = 8'h5C;
            else                                    d = 8'($urandom);
            ab = (l == opt_abort_line) && (b == opt_abort_byte);
            ar = (l == opt_arm_line) && (b == 0);
            abort_i = ab;
            arm_i   = ar;
            if (ab) begin
                m_cap   = 0;
                m_armed = 0;
            end else if (ar) begin
                model_arm();
            end
            if (b % 2 == 0) begin
                red = d[3:0];
            end else if (m_cap && (b / 2) < H && m_lines < V && m_addr < H * V) begin
                exp_addr_q.push_back(m_addr);
                exp_data_q.push_back(int'({d[3:0], d[7:4], red}));
                m_addr++;
            end
            tick(1'b0, 1'b1, d);
            arm_i   = 1'b0;
            abort_i = 1'b0;
            if (fixed_cap && b == 1) begin
                check("first_pix_wr_en", int'(wr_en_o), 1);
                check("first_pix_wr_data", int'(wr_data_o), 'hC5A);
            end
            if (fixed_cap && b == 2) check("first_pix_wr_en_1cyc", int'(wr_en_o), 0);
            if (ab) begin
                check("abort_wr_en", int'(wr_en_o), 0);
                check("abort_busy", int'(busy_o), 0);
            end
        end
        if (m_cap) begin
            if (nbytes != 2 * H) m_err = 1;
            if (m_lines < 1023) m_lines++;
        end
        was_cap = m_cap;
        tick(1'b0, 1'b0, 8'h00);
        if (was_cap) check("line_frame_err", int'(frame_err_o), int'(m_err));
        gap = $urandom_range(1, 3);
        repeat (gap) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_bytes);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) begin
            send_line(l, (l == bad_line) ? bad_bytes : 2 * H);
        end
        opt_abort_line = -1;
        opt_abort_byte = -1;
        opt_arm_line   = -1;
        opt_fixed      = 0;
    endtask

    // Compare process: every write and every frame_done against the model.
    always @(negedge cam_clk) begin : monitor
        int ea, ed;
        if (mon_en) begin
            if (chk_err_next) begin
                chk_err_next = 0;
                check("done_frame_err", int'(frame_err_o), pend_err);
            end
            if (wr_en_o) begin
                n_writes++;
                last_addr = int'(wr_addr_o);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_en: got write addr=%0d data=0x%0h, required none",
                             wr_addr_o, wr_data_o);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    check("wr_addr", int'(wr_addr_o), ea);
                    check("wr_data", int'(wr_data_o), ed);
                end
            end
            if (frame_done_o) begin
                n_done++;
                if (exp_done_lines_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got pulse, required none (t=%0t)", $time);
                end else begin
                    check("done_line_count", int'(line_count_o), exp_done_lines_q.pop_front());
                    pend_err     = exp_done_err_q.pop_front();
                    chk_err_next = 1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of run, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0, nl, bl, bb;
        repeat (3) @(negedge cam_clk);
        rstn = 1'b1;
        @(negedge cam_clk);
        check("rst_wr_en", int'(wr_en_o), 0);
        check("rst_wr_addr", int'(wr_addr_o), 0);
        check("rst_wr_data", int'(wr_data_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_frame_done", int'(frame_done_o), 0);
        check("rst_frame_err", int'(frame_err_o), 0);
        check("rst_line_count", int'(line_count_o), 0);
        mon_en = 1;

        // Arm in the middle of a line: that frame must not be captured.
        opt_arm_line = 1;
        send_frame(3, -1, 0);
        check("armed_busy", int'(busy_o), 1);
        w0 = n_writes;
        d0 = n_done;
        opt_fixed = 1;
        send_frame(3, -1, 0);
        vsync_pulse();
        check("t1_writes", n_writes - w0, 12);
        check("t1_last_addr", last_addr, 11);
        check("t1_done", n_done - d0, 1);
        check("t1_frame_err", int'(frame_err_o), 0);
        check("t1_line_count", int'(line_count_o), 3);
        check("t1_idle", int'(busy_o), 0);

        // Over-long line; an arm while capturing must not clear the error.
        do_arm();
        w0 = n_writes;
        opt_arm_line = 2;
        send_frame(3, 1, 10);
        vsync_pulse();
        check("t3_writes", n_writes - w0, 12);
        check("t3_frame_err", int'(frame_err_o), 1);
        do_arm();
        check("t3_err_cleared", int'(frame_err_o), 0);
        send_frame(3, -1, 0);
        vsync_pulse();
        check("t3_err_stays0", int'(frame_err_o), 0);

        // Continuous mode, last frame has one line too many.
        continuous_i = 1'b1;
        do_arm();
        d0 = n_done;
        w0 = n_writes;
        repeat (3) send_frame(3, -1, 0);
        send_frame(4, -1, 0);
        continuous_i = 1'b0;
        vsync_pulse();
        check("t4_done", n_done - d0, 4);
        check("t4_writes", n_writes - w0, 48);
        check("t4_frame_err", int'(frame_err_o), 1);
        check("t4_line_count", int'(line_count_o), 4);
        check("t4_idle", int'(busy_o), 0);

        // Abort on the second byte of a pixel in the second line.
        do_arm();
        d0 = n_done;
        w0 = n_writes;
        opt_abort_line = 1;
        opt_abort_byte = 3;
        send_frame(3, -1, 0);
        vsync_pulse();
        check("t5_writes", n_writes - w0, 5);
        check("t5_no_done", n_done - d0, 0);
        check("t5_idle", int'(busy_o), 0);

        // arm and abort together: abort wins.
        arm_i   = 1'b1;
        abort_i = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        arm_i   = 1'b0;
        abort_i = 1'b0;
        check("t6_arm_abort_idle", int'(busy_o), 0);
        send_frame(3, -1, 0);

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            continuous_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) do_arm();
            nl = $urandom_range(2, 4);
            bl = $urandom_range(0, 5);
            bb = $urandom_range(6, 11);
            send_frame(nl, (bl < nl) ? bl : -1, bb);
        end
        continuous_i = 1'b0;
        vsync_pulse();
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        check("end_writes_drained", exp_addr_q.size(), 0);
        check("end_dones_drained", exp_done_lines_q.size(), 0);
        check("end_idle", int'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
